countdown_timer_bcd: RTL and testbench

Parametrised successor to the single-purpose MM:SS countdown. Counts down a packed BCD time value once per clk_1s edge. Minute digits are configurable, and the count works digit-wise in BCD with borrow, with no binary-to-BCD division. Adds a run/pause/cancel state machine, load validation and a timed done/beeper output for the oven controller and display driver.

---
 rtl/countdown_timer_bcd.sv | 134 +++++++++++++
 tb/tb_countdown_timer_bcd.sv | 135 +++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: packed-BCD MM:SS countdown with run/pause/cancel FSM, load validation and timed done beep
// Optional feature macro: QUICK_ADD30_EN (adds the add30 quick-add / quick-start input).
// Ports:
//   clk_1s    - 1 Hz timing clock, all state updates on its rising edge
//   reset_n   - asynchronous active-low reset
//   load      - load time_in (accepted in IDLE, LOADED, DONE)
//   time_in   - packed BCD time, nibble 0 = seconds units, 1 = seconds tens, upper = minutes
//   start     - start from LOADED or resume from PAUSED
//   pause     - pause while RUNNING
//   cancel    - abort to IDLE and clear time (highest priority)
//   add30     - (QUICK_ADD30_EN only) add 30 s, saturating; quick-starts from IDLE
//   time_out  - remaining time, same packing as time_in
//   running   - state is RUNNING
//   paused    - state is PAUSED
//   done_beep - state is DONE (lasts DONE_CYCLES edges)
//   load_err  - one-cycle pulse when a load is rejected as invalid BCD
//   state_out - IDLE=0, LOADED=1, RUNNING=2, PAUSED=3, DONE=4
module countdown_timer_bcd #(
  parameter int MIN_DIGITS = 2,
  parameter int DONE_CYCLES = 3,
  localparam int ND = MIN_DIGITS + 2,
  localparam int W = 4 * ND
) (
  input  logic         clk_1s,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] time_in,
  input  logic         start,
  input  logic         pause,
  input  logic         cancel,
`ifdef QUICK_ADD30_EN
  input  logic         add30,
`endif
  output logic [W-1:0] time_out,
  output logic         running,
  output logic         paused,
  output logic         done_beep,
  output logic         load_err,
  output logic [2:0]   state_out
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOADED = 3'd1, RUNNING = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [W-1:0] time_q, time_d;
  logic [3:0] cnt_q, cnt_d;
  logic err_q, err_d;
  function automatic logic bcd_valid(input logic [W-1:0] t);
    bcd_valid = t[7:4] <= 4'd5;
    for (int i = 0; i < ND; i++) bcd_valid = bcd_valid && (t[4*i+:4] <= 4'd9);
  endfunction
  // Digit-wise decrement: each digit only moves when everything below it borrowed.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] t);
    logic b;
    logic [3:0] d;
    bcd_dec = t;
    b = (t != '0);
    for (int i = 0; i < ND; i++) begin
      d = t[4*i+:4];
      bcd_dec[4*i+:4] = b ? (d == 4'd0 ? (i == 1 ? 4'd5 : 4'd9) : d - 4'd1) : d;
      b = b && (d == 4'd0);
    end
  endfunction
`ifdef QUICK_ADD30_EN
  localparam logic [W-1:0] MAX_T = {{MIN_DIGITS{4'h9}}, 8'h59};
  // +3 on seconds tens, then ripple a carry through the minutes; carry out of the top digit saturates.
  function automatic logic [W-1:0] bcd_add30(input logic [W-1:0] t);
    logic c;
    logic [3:0] d;
    bcd_add30 = t;
    d = t[7:4] + 4'd3;
    c = d > 4'd5;
    bcd_add30[7:4] = c ? d - 4'd6 : d;
    for (int i = 2; i < ND; i++) begin
      d = t[4*i+:4];
      bcd_add30[4*i+:4] = c ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      c = c && (d == 4'd9);
    end
    if (c) bcd_add30 = MAX_T;
  endfunction
`endif
  always_comb begin
    state_d = state_q;
    time_d = time_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      time_d = '0;
      cnt_d = '0;
    end else if (load && (state_q == IDLE || state_q == LOADED || state_q == DONE)) begin
      if (bcd_valid(time_in)) begin
        time_d = time_in;
        state_d = (time_in == '0) ? IDLE : LOADED;
        cnt_d = '0;
      end else err_d = 1'b1;
    end
`ifdef QUICK_ADD30_EN
    else if (add30 && state_q != DONE) begin
      time_d = bcd_add30(time_q);
      state_d = (state_q == IDLE) ? RUNNING : state_q;
    end
`endif
    else if (start && (state_q == LOADED || state_q == PAUSED)) state_d = RUNNING;
    else if (pause && state_q == RUNNING) state_d = PAUSED;
    else if (state_q == RUNNING) begin
      time_d = bcd_dec(time_q);
      if (time_d == '0) begin
        state_d = DONE;
        cnt_d = 4'(DONE_CYCLES - 1);
      end
    end else if (state_q == DONE) begin
      state_d = (cnt_q == 4'd0) ? IDLE : DONE;
      cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk_1s or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      time_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q <= time_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign time_out = time_q;
  assign running = state_q == RUNNING;
  assign paused = state_q == PAUSED;
  assign done_beep = state_q == DONE;
  assign load_err = err_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb_countdown_timer_bcd: scoreboard bench for countdown_timer_bcd with directed hand-computed vectors
module tb_countdown_timer_bcd;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOADED = 3'd1, S_RUN = 3'd2, S_PAUSED = 3'd3, S_DONE = 3'd4;
  logic clk_1s = 1'b0, reset_n = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [15:0] time_in = '0;
`ifdef QUICK_ADD30_EN
  logic add30 = 1'b0;
`endif
  logic [15:0] time_out;
  logic running, paused, done_beep, load_err;
  logic [2:0] state_out;
  typedef struct {
    string n;
    logic [15:0] t;
    logic [2:0] s;
    logic b;
    logic e;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  event chk;
  countdown_timer_bcd dut (
    .clk_1s(clk_1s), .reset_n(reset_n), .load(load), .time_in(time_in),
    .start(start), .pause(pause), .cancel(cancel),
`ifdef QUICK_ADD30_EN
    .add30(add30),
`endif
    .time_out(time_out), .running(running), .paused(paused),
    .done_beep(done_beep), .load_err(load_err), .state_out(state_out)
  );
  always #5 clk_1s = ~clk_1s;
  always begin
    @(negedge clk_1s or chk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (time_out !== e.t || state_out !== e.s || running !== (e.s == S_RUN) || paused !== (e.s == S_PAUSED)
          || done_beep !== e.b || load_err !== e.e) begin
        n_bad++;
        $display("FAIL %s: got time=%h state=%0d run=%b pau=%b beep=%b err=%b, want time=%h state=%0d beep=%b err=%b",
                 e.n, time_out, state_out, running, paused, done_beep, load_err, e.t, e.s, e.b, e.e);
      end
    end
  end
  task automatic expect_now(input string n, input logic [15:0] et, input logic [2:0] es, input logic eb, input logic ee);
    exp_t e;
    e.n = n; e.t = et; e.s = es; e.b = eb; e.e = ee;
    q.push_back(e);
  endtask
  task automatic step(input string n, input logic ld, st, ps, cn, input logic [15:0] tin,
                      input logic [15:0] et, input logic [2:0] es, input logic eb, input logic ee);
    load = ld; start = st; pause = ps; cancel = cn; time_in = tin;
    @(posedge clk_1s);
    expect_now(n, et, es, eb, ee);
    @(negedge clk_1s);
    load = 0; start = 0; pause = 0; cancel = 0; time_in = '0;
  endtask
`ifdef QUICK_ADD30_EN
  task automatic step_add(input string n, input logic [15:0] et, input logic [2:0] es);
    add30 = 1'b1;
    step(n, 0, 0, 0, 0, 16'h0, et, es, 0, 0);
    add30 = 1'b0;
  endtask
`endif
  initial begin
    #3;
    expect_now("por_reset", 16'h0000, S_IDLE, 0, 0);
    ->chk;
    @(negedge clk_1s);
    reset_n = 1'b1;
    step("idle_start", 0, 1, 0, 0, 16'h0, 16'h0000, S_IDLE, 0, 0);
    step("load_0003", 1, 0, 0, 0, 16'h0003, 16'h0003, S_LOADED, 0, 0);
    step("start_E", 0, 1, 0, 0, 16'h0, 16'h0003, S_RUN, 0, 0);
    step("E+1", 0, 0, 0, 0, 16'h0, 16'h0002, S_RUN, 0, 0);
    step("E+2", 0, 0, 0, 0, 16'h0, 16'h0001, S_RUN, 0, 0);
    step("E+3_done", 0, 0, 0, 0, 16'h0, 16'h0000, S_DONE, 1, 0);
    step("done_2", 0, 1, 0, 0, 16'h0, 16'h0000, S_DONE, 1, 0);
    step("done_3", 0, 0, 0, 0, 16'h0, 16'h0000, S_DONE, 1, 0);
    step("done_idle", 0, 0, 0, 0, 16'h0, 16'h0000, S_IDLE, 0, 0);
    step("load_1000", 1, 0, 0, 0, 16'h1000, 16'h1000, S_LOADED, 0, 0);
    step("start_1000", 0, 1, 0, 0, 16'h0, 16'h1000, S_RUN, 0, 0);
    step("borrow_0959", 0, 0, 0, 0, 16'h0, 16'h0959, S_RUN, 0, 0);
    step("pause", 0, 0, 1, 0, 16'h0, 16'h0959, S_PAUSED, 0, 0);
    for (int i = 0; i < 5; i++) step("pause_hold", 0, 0, 0, 0, 16'h0, 16'h0959, S_PAUSED, 0, 0);
    step("resume", 0, 1, 0, 0, 16'h0, 16'h0959, S_RUN, 0, 0);
    step("run_0958", 0, 0, 0, 0, 16'h0, 16'h0958, S_RUN, 0, 0);
    step("cancel_load", 1, 0, 0, 1, 16'h0003, 16'h0000, S_IDLE, 0, 0);
    step("bad_tens_idle", 1, 0, 0, 0, 16'h0065, 16'h0000, S_IDLE, 0, 1);
    step("err_clears", 0, 0, 0, 0, 16'h0, 16'h0000, S_IDLE, 0, 0);
    step("load_0012", 1, 0, 0, 0, 16'h0012, 16'h0012, S_LOADED, 0, 0);
    step("bad_tens_loaded", 1, 0, 0, 0, 16'h0065, 16'h0012, S_LOADED, 0, 1);
    step("bad_min_nibble", 1, 0, 0, 0, 16'h0A00, 16'h0012, S_LOADED, 0, 1);
    step("load_zero", 1, 0, 0, 0, 16'h0000, 16'h0000, S_IDLE, 0, 0);
    step("load_0100", 1, 0, 0, 0, 16'h0100, 16'h0100, S_LOADED, 0, 0);
    step("start_0100", 0, 1, 0, 0, 16'h0, 16'h0100, S_RUN, 0, 0);
    step("borrow_0059", 0, 0, 0, 0, 16'h0, 16'h0059, S_RUN, 0, 0);
    step("load_in_run_ign", 1, 0, 0, 1, 16'h0100, 16'h0000, S_IDLE, 0, 0);
    step("load_max", 1, 0, 0, 0, 16'h9959, 16'h9959, S_LOADED, 0, 0);
    step("start_max", 0, 1, 0, 0, 16'h0, 16'h9959, S_RUN, 0, 0);
    step("max_9958", 0, 0, 0, 0, 16'h0, 16'h9958, S_RUN, 0, 0);
    step("pause_max", 0, 0, 1, 0, 16'h0, 16'h9958, S_PAUSED, 0, 0);
    step("cancel_paused", 0, 0, 0, 1, 16'h0, 16'h0000, S_IDLE, 0, 0);
    step("load_0001", 1, 0, 0, 0, 16'h0001, 16'h0001, S_LOADED, 0, 0);
    step("start_0001", 0, 1, 0, 0, 16'h0, 16'h0001, S_RUN, 0, 0);
    step("done_0001", 0, 0, 0, 0, 16'h0, 16'h0000, S_DONE, 1, 0);
    step("load_in_done", 1, 0, 0, 0, 16'h0005, 16'h0005, S_LOADED, 0, 0);
    step("load_0130", 1, 0, 0, 0, 16'h0130, 16'h0130, S_LOADED, 0, 0);
    step("start_0130", 0, 1, 0, 0, 16'h0, 16'h0130, S_RUN, 0, 0);
    step("run_0129", 0, 0, 0, 0, 16'h0, 16'h0129, S_RUN, 0, 0);
    #2 reset_n = 1'b0;
    #1 expect_now("async_reset", 16'h0000, S_IDLE, 0, 0);
    ->chk;
    @(negedge clk_1s);
    reset_n = 1'b1;
    step("after_reset", 0, 0, 0, 0, 16'h0, 16'h0000, S_IDLE, 0, 0);
`ifdef QUICK_ADD30_EN
    step_add("add30_idle", 16'h0030, S_RUN);
    step("add30_run", 0, 0, 0, 0, 16'h0, 16'h0029, S_RUN, 0, 0);
    step("add30_cancel", 0, 0, 0, 1, 16'h0, 16'h0000, S_IDLE, 0, 0);
    step("load_0045", 1, 0, 0, 0, 16'h0045, 16'h0045, S_LOADED, 0, 0);
    step_add("add30_0115", 16'h0115, S_LOADED);
    step("load_9950", 1, 0, 0, 0, 16'h9950, 16'h9950, S_LOADED, 0, 0);
    step_add("add30_sat", 16'h9959, S_LOADED);
`endif
    @(negedge clk_1s);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
